reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 32: register and data-port width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5: address width; register count = 2**ADDR_W (32 by default).
REQ-003 The block SHALL have parameter ZERO_REG0, default 1: when 1, register 0 is hardwired to zero.
Ports:
REQ-004 One clock and asynchronous active-low reset; the block SHALL provide clk input 1 bit: single clock, all state updates on the rising edge.
REQ-005 The block SHALL provide rst_n input 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL provide write_enable input 1 bit: enables the write port.
REQ-007 The block SHALL provide addr_1 input ADDR_W bits: read port 1 address.
REQ-008 The block SHALL provide addr_2 input ADDR_W bits: read port 2 address.
REQ-009 The block SHALL provide addr_3 input ADDR_W bits: write port address.
REQ-010 The block SHALL provide write_data input DATA_W bits: write port data.
REQ-011 The block SHALL provide read_data_1 output DATA_W bits: contents of register addr_1.
REQ-012 The block SHALL provide read_data_2 output DATA_W bits: contents of register addr_2.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits each.
REQ-014 Writes SHALL be synchronous: on the rising clk edge with rst_n=1 and write_enable=1, register[addr_3] <= write_data.
REQ-015 With write_enable=0, no register SHALL change at the clk edge.
REQ-016 Reads SHALL be combinational, zero-cycle latency: read_data_1 = register[addr_1] and read_data_2 = register[addr_2], updating in the same delta/cycle as an address change.
REQ-017 Both read ports SHALL be fully independent; equal addr_1 and addr_2 SHALL return identical data.
REQ-018 Read-during-write to the same address SHALL return the old value until the write edge, then the new value; there is no write-to-read bypass.
REQ-019 With ZERO_REG0=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0.
REQ-020 With ZERO_REG0=0, register 0 SHALL behave as an ordinary register.
REQ-021 Addresses SHALL be interpreted as unsigned and cover the full range 0..2**ADDR_W-1; no out-of-range case exists.
REQ-022 Write data SHALL be stored bit-exact, with no sign extension or truncation.

Reset
REQ-023 When rst_n=0, all registers SHALL clear to 0 immediately and asynchronously, independent of clk.
REQ-024 While rst_n=0, writes SHALL be ignored and both read ports SHALL output 0 for all addresses.
REQ-025 On rst_n deassertion, the first write SHALL take effect at the first rising clk edge where rst_n=1.
REQ-026 Reset asserted mid-operation SHALL discard all prior contents.

Verification
REQ-027 Fill test: with write_enable=1, write_data=i to addr_3=i for i=0..31 (one per cycle), then sweep addr_1 and addr_2 over 1..31 -> read_data_1 = read_data_2 = i; address 0 reads 0.
REQ-028 Zero-register test: write 0xFFFFFFFF to addr_3=0 -> read_data_1 at addr_1=0 = 0.
REQ-029 Write-enable test: write_enable=0, write_data=0xDEADBEEF, addr_3=5, clock -> register 5 keeps its prior value.
REQ-030 Same-address test: addr_1=addr_3=7 with write_data=0x12345678 -> read_data_1 shows the old value before the edge and 0x12345678 after it.
REQ-031 Reset test: after the fill, pulse rst_n=0 between clock edges -> all reads return 0 immediately; a write of 0xA5 to address 3 after release reads back 0xA5.
REQ-032 Dual-port test: addr_1=10, addr_2=20 after the fill -> read_data_1=10 and read_data_2=20 simultaneously.

Source files
------------

// File: rtl/reg_file.sv
// Register file: 2**ADDR_W x DATA_W, two combinational read ports, one synchronous write port.
// Latency: reads zero-cycle, writes visible after the rising edge; no backpressure, a write is accepted every cycle.
module reg_file #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int ZERO_REG0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [ADDR_W-1:0] addr_3,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2
);

  localparam int NREG    = 1 << ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG0 != 0);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_ok;

  // Writes to a hardwired-zero register 0 are dropped rather than stored.
  assign wr_ok = write_enable && !(ZERO_EN && (addr_3 == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[addr_3] <= write_data;
    end
  end

  // No write-to-read bypass: ports see the stored value until the write edge.
  always_comb begin
    read_data_1 = regs[addr_1];
    if (!rst_n || (ZERO_EN && (addr_1 == '0))) begin
      read_data_1 = '0;
    end
  end

  always_comb begin
    read_data_2 = regs[addr_2];
    if (!rst_n || (ZERO_EN && (addr_2 == '0))) begin
      read_data_2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: fill/sweep via scoreboard queue, table-driven vectors, hand-written reset sequence.
module tb_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] a1 = '0;
  logic [AW-1:0] a2 = '0;
  logic [AW-1:0] a3 = '0;
  logic [DW-1:0] wd = '0;
  logic [DW-1:0] rd1, rd2, nz_rd1, nz_rd2;

  reg_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG0(1)) dut (
    .clk(clk), .rst_n(rst_n), .write_enable(we),
    .addr_1(a1), .addr_2(a2), .addr_3(a3), .write_data(wd),
    .read_data_1(rd1), .read_data_2(rd2)
  );

  reg_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG0(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .write_enable(we),
    .addr_1(a1), .addr_2(a2), .addr_3(a3), .write_data(wd),
    .read_data_1(nz_rd1), .read_data_2(nz_rd2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [32];

  typedef struct {
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
    logic [DW-1:0] pre1;
    logic [DW-1:0] pre2;
    logic [DW-1:0] post1;
    logic [DW-1:0] post2;
  } vec_t;
  vec_t vt[7];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    e.e1 = e1;
    e.e2 = e2;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h/%h expected an entry", nm, rd1, rd2);
    end else begin
      e = sb.pop_front();
      check({nm, "_p1"}, rd1, e.e1);
      check({nm, "_p2"}, rd2, e.e2);
    end
  endtask

  initial begin
    vt[0] = '{1'b0, 5'd10, 5'd20, 5'd0, 32'h0,        32'd10, 32'd20, 32'd10,       32'd20};
    vt[1] = '{1'b1, 5'd0,  5'd0,  5'd0, 32'hFFFFFFFF, 32'd0,  32'd0,  32'd0,        32'd0};
    vt[2] = '{1'b0, 5'd5,  5'd5,  5'd5, 32'hDEADBEEF, 32'd5,  32'd5,  32'd5,        32'd5};
    vt[3] = '{1'b1, 5'd7,  5'd8,  5'd7, 32'h12345678, 32'd7,  32'd8,  32'h12345678, 32'd8};
    vt[4] = '{1'b0, 5'd7,  5'd7,  5'd0, 32'h0,        32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vt[5] = '{1'b1, 5'd31, 5'd30, 5'd31, 32'h80000001, 32'd31, 32'd30, 32'h80000001, 32'd30};
    vt[6] = '{1'b1, 5'd1,  5'd2,  5'd1, 32'hFFFFFFFF, 32'd1,  32'd2,  32'hFFFFFFFF, 32'd2};

    for (int i = 0; i < 32; i++) model[i] = '0;

    // Power-on reset
    #1 rst_n = 1'b0;
    #2;
    a1 = 5'd3; a2 = 5'd31;
    #1;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill: first write lands on the first rising edge after release
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; a3 = AW'(i); wd = DW'(i);
      @(posedge clk);
      if (i != 0) model[i] = DW'(i);
      @(negedge clk);
    end
    we = 1'b0;

    // Sweep both ports in opposite directions
    for (int i = 0; i < 32; i++) begin
      if (i != 0) @(negedge clk);
      a1 = AW'(i); a2 = AW'(31 - i);
      push(model[i], model[31 - i]);
      #1;
      pop_cmp($sformatf("sweep%0d", i));
    end

    // Table vectors: check before and after the edge
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      we = vt[k].we; a1 = vt[k].a1; a2 = vt[k].a2; a3 = vt[k].a3; wd = vt[k].wd;
      push(vt[k].pre1, vt[k].pre2);
      #1;
      pop_cmp($sformatf("vec%0d_pre", k));
      @(posedge clk);
      #1;
      push(vt[k].post1, vt[k].post2);
      pop_cmp($sformatf("vec%0d_post", k));
    end
    @(negedge clk);
    we = 1'b0;

    // Register 0 is ordinary when not hardwired
    a1 = 5'd0; a2 = 5'd10;
    #1;
    check("nz_reg0", nz_rd1, 32'hFFFFFFFF);
    check("nz_reg10", nz_rd2, 32'd10);
    check("z_reg0", rd1, 32'h0);

    // Mid-operation reset between edges
    @(negedge clk);
    a1 = 5'd3; a2 = 5'd31;
    #2;
    check("pre_rst_rd1", rd1, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_imm_rd1", rd1, 32'h0);
    check("rst_imm_rd2", rd2, 32'h0);
    we = 1'b1; a3 = 5'd3; wd = 32'h55;
    @(posedge clk);
    #1;
    check("rst_wr_ignored", rd1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b1; a3 = 5'd3; wd = 32'hA5; a1 = 5'd3; a2 = 5'd7;
    #1;
    check("post_rst_rd1", rd1, 32'h0);
    check("post_rst_discard7", rd2, 32'h0);
    check("post_rst_nz7", nz_rd2, 32'h0);
    @(posedge clk);
    #1;
    check("post_rst_wr_a5", rd1, 32'hA5);
    check("post_rst_nz_a5", nz_rd1, 32'hA5);
    @(negedge clk);
    we = 1'b0; a1 = 5'd31;
    #1;
    check("post_rst_discard31", rd1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
